// File: rtl/ieeedrv_headpos.sv
// ieeedrv_headpos: head position tracker for one IEEE-488 floppy subdrive.
// Decodes the two-bit stepper phase into inward/outward half-track steps,
// keeps the half-track position within the limits of the selected drive
// type, times head settling after each step, and tracks whether the current
// track buffer has been modified so it can be written back before the head
// moves away or the motor stops.
module ieeedrv_headpos #(
  parameter logic [15:0] SETTLE = 16'd3000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       drv_type,
  input  logic       mounted,
  input  logic       selected,
  input  logic       mtr,
  input  logic [1:0] stp,
  input  logic       we,
  output logic [7:0] htrack,
  output logic [7:0] track,
  output logic       track_changing,
  output logic       save_track,
  output logic       dirty
);

  // Highest legal half-track for each drive type.
  localparam logic [7:0] HMAX_4040 = 8'd68;
  localparam logic [7:0] HMAX_8250 = 8'd152;

  logic [1:0]  stp_l;
  logic        mtr_l;
  logic [15:0] settle_cnt;

  logic [1:0]  stp_fwd;
  logic [1:0]  stp_back;
  logic        step_in;
  logic        step_out;
  logic        step_acc;
  logic        mtr_fall;
  logic        save_trig;
  logic [7:0]  hmax;
  logic [7:0]  pos_base;
  logic [7:0]  htrack_next;
  logic [15:0] settle_next;
  logic        dirty_next;

  // Whole track is the half-track position with the half-step bit dropped.
  assign track = {1'b0, htrack[7:1]};

  // Decode the phase change, apply position limits, and work out the next
  // settle count, dirty flag and write-back request for this ce tick.
  always_comb begin
    stp_fwd     = stp_l + 2'd1;
    stp_back    = stp_l - 2'd1;
    step_in     = 1'b0;
    step_out    = 1'b0;
    step_acc    = 1'b0;
    mtr_fall    = 1'b0;
    save_trig   = 1'b0;
    hmax        = drv_type ? HMAX_4040 : HMAX_8250;
    pos_base    = htrack;
    htrack_next = htrack;
    settle_next = settle_cnt;
    dirty_next  = dirty;

    // A phase two away from the last one is ambiguous and is ignored.
    step_in  = (stp == stp_fwd);
    step_out = (stp == stp_back);
    step_acc = ce & mtr & selected & (step_in | step_out);
    mtr_fall = mtr_l & ~mtr;

    // A drive-type change can leave the head beyond the new last track.
    if (htrack > hmax) begin
      pos_base = hmax;
    end

    htrack_next = pos_base;
    if (step_acc && step_in) begin
      if (pos_base < hmax) begin
        htrack_next = pos_base + 8'd1;
      end
    end else if (step_acc && step_out) begin
      if (pos_base != 8'd0) begin
        htrack_next = pos_base - 8'd1;
      end
    end

    // Saturated steps still restart settling: the stepper was driven.
    if (step_acc) begin
      settle_next = SETTLE;
    end else if (mounted) begin
      settle_next = 16'd0;
    end else if (settle_cnt != 16'd0) begin
      settle_next = settle_cnt - 16'd1;
    end

    // Only the first step of a seek requests a save; later steps arrive
    // while the head is still settling.
    save_trig = ce & dirty & ~mounted &
                ((step_acc & ~track_changing) | mtr_fall);

    // A write on the same tick as a save marks the fresh buffer dirty again.
    if (mounted) begin
      dirty_next = 1'b0;
    end else if (we && mtr && selected) begin
      dirty_next = 1'b1;
    end else if (save_trig) begin
      dirty_next = 1'b0;
    end
  end

  // State registers: everything advances on ce except the one-cycle save pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stp_l          <= 2'd0;
      mtr_l          <= 1'b0;
      htrack         <= 8'd0;
      settle_cnt     <= 16'd0;
      track_changing <= 1'b0;
      save_track     <= 1'b0;
      dirty          <= 1'b0;
    end else begin
      save_track <= save_trig;
      if (ce) begin
        stp_l          <= stp;
        mtr_l          <= mtr;
        htrack         <= htrack_next;
        settle_cnt     <= settle_next;
        track_changing <= (settle_next != 16'd0);
        dirty          <= dirty_next;
      end
    end
  end

endmodule

// File: tb/tb_ieeedrv_headpos.sv
// tb_ieeedrv_headpos: directed and randomized checks of the head position
// tracker against a behavioural model of the drive mechanics.
module tb_ieeedrv_headpos;

  localparam logic [15:0] SETTLE_T = 16'd8;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       drv_type;
  logic       mounted;
  logic       selected;
  logic       mtr;
  logic [1:0] stp;
  logic       we;
  logic [7:0] htrack;
  logic [7:0] track;
  logic       track_changing;
  logic       save_track;
  logic       dirty;

  ieeedrv_headpos #(.SETTLE(SETTLE_T)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ce             (ce),
    .drv_type       (drv_type),
    .mounted        (mounted),
    .selected       (selected),
    .mtr            (mtr),
    .stp            (stp),
    .we             (we),
    .htrack         (htrack),
    .track          (track),
    .track_changing (track_changing),
    .save_track     (save_track),
    .dirty          (dirty)
  );

  always #5 clk_sys = ~clk_sys;

  int compare_count = 0;
  int fail_count    = 0;
  int save_seen     = 0;

  // Behavioural model of the drive head and track buffer.
  int m_htrack;
  int m_cnt;
  int m_stp_l;
  bit m_dirty;
  bit m_save;
  bit m_mtr_l;

  int cur_stp;
  bit cur_drv;
  int hold_pos;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compare_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_htrack = 0;
    m_cnt    = 0;
    m_stp_l  = 0;
    m_dirty  = 0;
    m_save   = 0;
    m_mtr_l  = 0;
  endtask

  task automatic model_step();
    int  delta;
    int  hmax;
    int  pos;
    bit  acc;
    bit  inward;
    bit  trig;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_save = 0;
    if (ce) begin
      delta  = (int'(stp) - m_stp_l) & 3;
      inward = (delta == 1);
      acc    = (delta == 1 || delta == 3) && mtr && selected;
      hmax   = drv_type ? 68 : 152;
      pos    = (m_htrack > hmax) ? hmax : m_htrack;
      if (acc && inward && pos < hmax) pos = pos + 1;
      if (acc && !inward && pos > 0)   pos = pos - 1;
      trig = m_dirty && !mounted && ((acc && m_cnt == 0) || (m_mtr_l && !mtr));
      if (acc)            m_cnt = SETTLE_T;
      else if (mounted)   m_cnt = 0;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (mounted)                   m_dirty = 0;
      else if (we && mtr && selected) m_dirty = 1;
      else if (trig)                 m_dirty = 0;
      m_htrack = pos;
      m_stp_l  = int'(stp);
      m_mtr_l  = mtr;
      m_save   = trig;
    end
  endtask

  task automatic checkOutput();
    check_eq("htrack", 16'(htrack), 16'(m_htrack));
    check_eq("track", 16'(track), 16'(m_htrack / 2));
    check_eq("track_changing", 16'(track_changing), 16'(m_cnt != 0));
    check_eq("save_track", 16'(save_track), 16'(m_save));
    check_eq("dirty", 16'(dirty), 16'(m_dirty));
    if (save_track === 1'b1) save_seen++;
  endtask

  task automatic applyStimulus(input bit ce_i, input int stp_i, input bit mtr_i,
                               input bit sel_i, input bit we_i, input bit mnt_i);
    ce       = ce_i;
    stp      = 2'(stp_i);
    mtr      = mtr_i;
    selected = sel_i;
    we       = we_i;
    mounted  = mnt_i;
    drv_type = cur_drv;
    @(posedge clk_sys);
    model_step();
    #1;
    checkOutput();
  endtask

  task automatic step_head(input int dir);
    cur_stp = (cur_stp + dir) & 3;
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    ce       = 1'b0;
    drv_type = 1'b1;
    mounted  = 1'b0;
    selected = 1'b0;
    mtr      = 1'b0;
    stp      = 2'd0;
    we       = 1'b0;
    cur_stp  = 0;
    cur_drv  = 1'b1;
    model_reset();

    // Reset state
    #2 reset_n = 1'b0;
    #1 checkOutput();
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Seek four half-tracks inward with gaps of no-ce cycles
    for (int i = 0; i < 4; i++) begin
      step_head(1);
      applyStimulus(1'b0, cur_stp, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    check_eq("seek_htrack", 16'(htrack), 16'd4);
    check_eq("seek_track", 16'(track), 16'd2);
    check_eq("seek_settling", 16'(track_changing), 16'd1);
    idle(int'(SETTLE_T) - 1);
    check_eq("settle_last_tick", 16'(track_changing), 16'd1);
    idle(1);
    check_eq("settle_done", 16'(track_changing), 16'd0);

    // Outward to zero, then one more outward step saturates but reloads
    for (int i = 0; i < 4; i++) step_head(-1);
    idle(int'(SETTLE_T));
    step_head(-1);
    check_eq("floor_htrack", 16'(htrack), 16'd0);
    check_eq("floor_reload", 16'(track_changing), 16'd1);

    // 8250 upper limit, then switch to 4040 from half-track 100
    cur_drv = 1'b0;
    for (int i = 0; i < 152; i++) step_head(1);
    check_eq("ceil_8250", 16'(htrack), 16'd152);
    step_head(1);
    check_eq("ceil_8250_sat", 16'(htrack), 16'd152);
    for (int i = 0; i < 52; i++) step_head(-1);
    check_eq("pos_100", 16'(htrack), 16'd100);
    cur_drv = 1'b1;
    idle(1);
    check_eq("clamp_4040", 16'(htrack), 16'd68);

    // Ambiguous phase and gated steps
    idle(int'(SETTLE_T) + 2);
    hold_pos = int'(htrack);
    cur_stp = (cur_stp + 2) & 3;
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("illegal_step", 16'(htrack), 16'(hold_pos));
    cur_stp = (cur_stp + 3) & 3;
    applyStimulus(1'b1, cur_stp, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("mtr_off_step", 16'(htrack), 16'(hold_pos));
    check_eq("mtr_off_settle", 16'(track_changing), 16'd0);
    cur_stp = (cur_stp + 3) & 3;
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("unselected_step", 16'(htrack), 16'(hold_pos));
    check_eq("unselected_settle", 16'(track_changing), 16'd0);

    // Write then a three-step seek: one save at the start of the seek
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("dirty_set", 16'(dirty), 16'd1);
    save_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step_head(-1);
      applyStimulus(1'b0, cur_stp, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    idle(2);
    check_eq("seek_save_count", 16'(save_seen), 16'd1);
    check_eq("seek_save_clean", 16'(dirty), 16'd0);

    // Write then motor off: one save
    idle(int'(SETTLE_T));
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b1, 1'b0);
    save_seen = 0;
    applyStimulus(1'b1, cur_stp, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("mtr_fall_pulse", 16'(save_track), 16'd1);
    applyStimulus(1'b0, cur_stp, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, cur_stp, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("mtr_fall_count", 16'(save_seen), 16'd1);
    check_eq("mtr_fall_clean", 16'(dirty), 16'd0);

    // Write on the same tick as the save trigger keeps the buffer dirty
    idle(1);
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b1, 1'b0);
    cur_stp = (cur_stp + 1) & 3;
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("write_after_save_pulse", 16'(save_track), 16'd1);
    check_eq("write_after_save_dirty", 16'(dirty), 16'd1);

    // Mount with a simultaneous step: no save, clean, head moves
    idle(int'(SETTLE_T));
    hold_pos = int'(htrack);
    cur_stp = (cur_stp + 1) & 3;
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("mount_no_save", 16'(save_track), 16'd0);
    check_eq("mount_clean", 16'(dirty), 16'd0);
    check_eq("mount_step", 16'(htrack), 16'(hold_pos + 1));
    check_eq("mount_reload", 16'(track_changing), 16'd1);

    // Reset in the middle of settling
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b1, 1'b0);
    step_head(1);
    idle(2);
    #2 reset_n = 1'b0;
    model_reset();
    #1 checkOutput();
    applyStimulus(1'b1, cur_stp, 1'b1, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    cur_stp = 0;
    idle(3);

    // Randomized operation against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) cur_drv = ~cur_drv;
      cur_stp = int'($urandom_range(3));
      applyStimulus(1'($urandom_range(1)), cur_stp,
                    1'($urandom_range(7) != 0), 1'($urandom_range(7) != 0),
                    1'($urandom_range(5) == 0), 1'($urandom_range(99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ieeedrv_headpos.md
IEEEDRV_HEADPOS -- requirements
Module: ieeedrv_headpos

Interface
REQ-001 SHALL have parameter SETTLE, default 16'd3000, head-settle time in ce ticks after the last accepted step.
REQ-002 SHALL have port clk_sys  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ce  input  1  drive clock enable; all sampling, stepping and counting occur only on cycles with ce=1.
REQ-005 SHALL have port drv_type  input  1  1=4040 (35 tracks), 0=8250 (77 tracks).
REQ-006 SHALL have port mounted  input  1  one-cycle image-mount pulse.
REQ-007 SHALL have port selected  input  1  this subdrive is the active unit.
REQ-008 SHALL have port mtr  input  1  spindle motor on.
REQ-009 SHALL have port stp  input  2  stepper phase from controller logic.
REQ-010 SHALL have port we  input  1  write-gate active (data being written to current track).
REQ-011 SHALL have port htrack  output  8  half-track position, 0-based.
REQ-012 SHALL have port track  output  8  whole track, 0-based (htrack[7:1]).
REQ-013 SHALL have port track_changing  output  1  head moving/settling.
REQ-014 SHALL have port save_track  output  1  one-clk_sys pulse requesting write-back of current track buffer.
REQ-015 SHALL have port dirty  output  1  current track buffer modified since load/save.

Function
REQ-016 SHALL register stp into stp_l on every ce.
REQ-017 Step decode: stp==stp_l+1 (mod 4) = inward; stp==stp_l-1 (mod 4) = outward; equal or differ by 2 = no step.
REQ-018 A decoded step SHALL be accepted only if mtr=1 and selected=1; otherwise ignored (stp_l still updates).
REQ-019 Accepted inward step: htrack+1, saturating at HMAX = 68 (drv_type=1) or 152 (drv_type=0); outward: htrack-1, saturating at 0.
REQ-020 Saturated steps (no position change) SHALL still count as accepted for settle-timer purposes.
REQ-021 If drv_type changes and htrack>HMAX for the new type, htrack SHALL clamp to HMAX on the next ce.
REQ-022 Settle counter (16 bit): loaded with SETTLE on accepted step; otherwise decrements by 1 per ce while nonzero.
REQ-023 track_changing SHALL equal (settle counter != 0), registered; asserted in the cycle after the accepting ce.
REQ-024 dirty SHALL set on a ce with we=1, mtr=1, selected=1.
REQ-025 dirty SHALL clear in the same cycle save_track pulses, and on mounted=1.
REQ-026 save_track SHALL pulse for exactly one clk_sys cycle (the cycle after the triggering ce) when dirty=1 and either: (a) a step is accepted while track_changing=0, or (b) mtr falls (1->0, sampled on ce).
REQ-027 Steps accepted while track_changing=1 SHALL not pulse save_track (one save per seek sequence).
REQ-028 mounted=1 SHALL clear dirty and settle counter, suppress save_track that ce, and leave htrack unchanged; a step on the same ce is still applied and reloads the counter.
REQ-029 we=1 on the same ce as a save trigger: save_track pulses and dirty stays set (write after save).
REQ-030 Inputs SHALL take effect only on ce cycles; outputs SHALL hold between ce cycles except save_track, which returns to 0 after one clk_sys cycle.

Reset
REQ-031 On reset_n=0, asynchronously: htrack=0, track=0, stp_l=0, settle counter=0, track_changing=0, save_track=0, dirty=0.
REQ-032 Reset mid-seek SHALL abort settling with no save_track pulse; operation resumes on the first ce after reset_n rises.

Verification
REQ-033 Seek: drv_type=1, mtr=selected=1, stp 0->1->2->3->0 on successive ces -> htrack 1,2,3,4, track=2; track_changing high until SETTLE ces after last step.
REQ-034 Bounds: at htrack=0 step outward -> htrack stays 0, counter reloads; drv_type=0 at htrack=152 step inward -> stays 152; switch drv_type 0->1 at htrack=100 -> htrack=68 next ce.
REQ-035 Illegal/gated: stp 0->2 -> no change; step with mtr=0 or selected=0 -> htrack unchanged, track_changing=0.
REQ-036 Save: we=1 one ce, then 3 steps -> exactly one save_track pulse after first step, dirty=0 afterwards; we=1 then mtr 1->0 -> one pulse.
REQ-037 Mount/reset: dirty=1, mounted pulse with simultaneous step -> no save_track, dirty=0, htrack changes by 1; reset_n low mid-settle -> all outputs 0 immediately.
